// File: rtl/boxcar_decimator.sv
// boxcar_decimator: averages 2^D enabled input samples and emits one mean sample
// with a single-cycle valid pulse; D is latched at each window start.
`default_nettype none

module boxcar_decimator #(
   parameter int WIDTH               = 14,
   parameter int LOG2_MAX_DECIMATION = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ce_i,
   input  logic [3:0]       log2_decimation_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             data_valid_o,
   output logic [WIDTH-1:0] data_o
);

   localparam int         CNT_W = LOG2_MAX_DECIMATION;
   localparam int         ACC_W = WIDTH + LOG2_MAX_DECIMATION;
   localparam logic [3:0] D_MAX = 4'(LOG2_MAX_DECIMATION);

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [3:0]              d_q, d_d;
   logic [WIDTH-1:0]        data_q, data_d;
   logic                    valid_q, valid_d;

   logic [3:0]              d_req;
   logic [3:0]              d_eff;
   logic                    win_start;
   logic                    win_last;
   logic [CNT_W-1:0]        last_cnt;
   logic signed [ACC_W-1:0] sample_ext;
   logic signed [ACC_W-1:0] sum;

   assign d_req     = (log2_decimation_i > D_MAX) ? D_MAX : log2_decimation_i;
   assign win_start = ce_i && (cnt_q == '0);
   assign d_eff     = win_start ? d_req : d_q;

   // Wraps to all-ones when d_eff equals the counter width, which is the intended 2^D-1.
   assign last_cnt   = (CNT_W'(1) << d_eff) - CNT_W'(1);
   assign win_last   = (cnt_q == last_cnt);
   assign sample_ext = {{LOG2_MAX_DECIMATION{data_i[WIDTH-1]}}, data_i};
   assign sum        = acc_q + sample_ext;

   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      d_d     = d_q;
      data_d  = data_q;
      valid_d = 1'b0;
      if (ce_i) begin
         if (win_start) begin
            d_d = d_req;
         end
         if (win_last) begin
            // Arithmetic shift of a signed sum rounds toward minus infinity.
            data_d  = WIDTH'(sum >>> d_eff);
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         d_q     <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         d_q     <= d_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_boxcar_decimator.sv
// Directed self-checking bench for boxcar_decimator with hand-computed expectations.
`default_nettype none

module tb_boxcar_decimator;

   localparam int WIDTH = 14;
   localparam int LOG2_MAX_DECIMATION = 10;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             ce_i = 1'b0;
   logic [3:0]       log2_decimation_i = 4'd0;
   logic [WIDTH-1:0] data_i = '0;
   logic             data_valid_o;
   logic [WIDTH-1:0] data_o;

   int checks = 0;
   int errors = 0;

   boxcar_decimator #(
      .WIDTH               (WIDTH),
      .LOG2_MAX_DECIMATION (LOG2_MAX_DECIMATION)
   ) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .ce_i              (ce_i),
      .log2_decimation_i (log2_decimation_i),
      .data_i            (data_i),
      .data_valid_o      (data_valid_o),
      .data_o            (data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic ce, input logic [3:0] ld, input int x);
      @(negedge clk_i);
      ce_i              = ce;
      log2_decimation_i = ld;
      data_i            = x[WIDTH-1:0];
      @(posedge clk_i);
      #1;
   endtask

   function automatic int dout();
      return int'($signed(data_o));
   endfunction

   initial begin
      int early;
      int gap_ce[7];
      int gap_x[7];
      gap_ce = '{1, 0, 0, 1, 1, 0, 1};
      gap_x  = '{10, 0, 0, 20, 30, 0, 40};

      // Reset state
      #12;
      check("reset_valid", int'(data_valid_o), 0);
      check("reset_data", dout(), 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // DC input, D=2: pulse every 4th enabled sample
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 4'd2, 100);
         check($sformatf("dc_valid_%0d", i), int'(data_valid_o), (i % 4 == 3) ? 1 : 0);
         if (i % 4 == 3) check($sformatf("dc_data_%0d", i), dout(), 100);
      end

      // Negative rounding toward -inf, D=1
      step(1'b1, 4'd1, -3);
      check("neg_mid_valid", int'(data_valid_o), 0);
      step(1'b1, 4'd1, -4);
      check("neg_valid", int'(data_valid_o), 1);
      check("neg_data", dout(), -4);
      step(1'b1, 4'd1, 3);
      step(1'b1, 4'd1, 4);
      check("pos_valid", int'(data_valid_o), 1);
      check("pos_data", dout(), 3);

      // Gapped enable, D=2
      for (int i = 0; i < 7; i++) begin
         step(gap_ce[i] != 0, 4'd2, gap_x[i]);
         check($sformatf("gap_valid_%0d", i), int'(data_valid_o), (i == 6) ? 1 : 0);
      end
      check("gap_data", dout(), 25);
      step(1'b0, 4'd2, 0);
      check("gap_after_valid", int'(data_valid_o), 0);
      check("gap_hold_data", dout(), 25);

      // Mid-window change of D from 2 to 0
      step(1'b1, 4'd2, 1);
      step(1'b1, 4'd2, 2);
      step(1'b1, 4'd0, 3);
      check("mid_3rd_valid", int'(data_valid_o), 0);
      step(1'b1, 4'd0, 6);
      check("mid_4th_valid", int'(data_valid_o), 1);
      check("mid_4th_data", dout(), 3);
      step(1'b1, 4'd0, -5);
      check("d0_a_valid", int'(data_valid_o), 1);
      check("d0_a_data", dout(), -5);
      step(1'b1, 4'd0, 7);
      check("d0_b_valid", int'(data_valid_o), 1);
      check("d0_b_data", dout(), 7);
      step(1'b0, 4'd0, 9);
      check("d0_idle_valid", int'(data_valid_o), 0);

      // Clamp to D=10 with full-scale negative then positive input
      early = 0;
      for (int i = 0; i < 1024; i++) begin
         step(1'b1, 4'd15, -8192);
         if (i < 1023 && data_valid_o) early++;
      end
      check("min_early_pulses", early, 0);
      check("min_valid", int'(data_valid_o), 1);
      check("min_data", dout(), -8192);
      early = 0;
      for (int i = 0; i < 1024; i++) begin
         step(1'b1, 4'd15, 8191);
         if (i < 1023 && data_valid_o) early++;
      end
      check("max_early_pulses", early, 0);
      check("max_valid", int'(data_valid_o), 1);
      check("max_data", dout(), 8191);

      // Asynchronous reset mid-window, D=3
      for (int i = 0; i < 5; i++) step(1'b1, 4'd3, 1000);
      check("pre_rst_valid", int'(data_valid_o), 0);
      check("pre_rst_hold", dout(), 8191);
      #2;
      rst_ni = 1'b0;
      #1;
      check("arst_valid", int'(data_valid_o), 0);
      check("arst_data", dout(), 0);
      @(negedge clk_i);
      ce_i   = 1'b0;
      rst_ni = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 4'd3, 50);
         check($sformatf("post_rst_valid_%0d", i), int'(data_valid_o), (i == 7) ? 1 : 0);
      end
      check("post_rst_data", dout(), 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
